// File: rtl/chunked_add_sub_pkg.sv
// Shared definitions for the chunked adder/subtractor: FSM state encoding
// and default operand/chunk widths.
package chunked_add_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;
  localparam int unsigned DEFAULT_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : chunked_add_sub_pkg

// File: rtl/chunked_add_sub_add_chunk.sv
// add_chunk: CHUNK-bit combinational adder with carry-in, carry-out and an
// optional inversion of the b operand (used for a + ~b + 1 subtraction).
// Ports:
//   a_i, b_i   CHUNK-bit operands
//   inv_i      1 = use ~b_i
//   cin_i      carry in
//   sum_o      CHUNK-bit sum
//   cout_o     carry out of the chunk MSB
module add_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             inv_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  logic [CHUNK-1:0] b_eff;

  assign b_eff = b_i ^ {CHUNK{inv_i}};
  assign {cout_o, sum_o} = (CHUNK+1)'(a_i) + (CHUNK+1)'(b_eff) + (CHUNK+1)'(cin_i);

endmodule : add_chunk

// File: rtl/chunked_add_sub.sv
// chunked_add_sub: multi-cycle adder/subtractor that processes CHUNK bits per
// clock, LSB chunk first, reusing a single add_chunk instance.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    operand handshake (ready only in IDLE)
//   a, b, sub              operands; sub=1 computes a - b
//   out_valid / out_ready  result handshake (valid only in DONE)
//   result, cout, ovf, zero  registered result and flags
module chunked_add_sub
  import chunked_add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Refuse to elaborate when the width is not a whole number of chunks.
  if ((CHUNK == 0) || ((WIDTH % CHUNK) != 0)) begin : g_bad_chunk
    $error("chunked_add_sub: WIDTH must be an integer multiple of CHUNK");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               sub_q, sub_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [CHUNK-1:0]   sum_c;
  logic               chunk_cout_c;
  logic [WIDTH-1:0]   acc_next_c;
  logic               ovf_next_c;

  // Operands shift right each RUN cycle, so the current chunk is always the low CHUNK bits.
  add_chunk #(.CHUNK(CHUNK)) u_add_chunk (
    .a_i    (a_q[CHUNK-1:0]),
    .b_i    (b_q[CHUNK-1:0]),
    .inv_i  (sub_q),
    .cin_i  (carry_q),
    .sum_o  (sum_c),
    .cout_o (chunk_cout_c)
  );

  // New chunk enters at the top of the accumulator; after NCHUNK steps it is aligned.
  assign acc_next_c = WIDTH'({sum_c, acc_q} >> CHUNK);

  // On the last chunk the low bits of a_q/b_q hold the original operand MSBs.
  assign ovf_next_c = (a_q[CHUNK-1] == (b_q[CHUNK-1] ^ sub_q)) &&
                      (sum_c[CHUNK-1] != a_q[CHUNK-1]);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sub_q       <= 1'b0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      acc_q       <= '0;
      result_q    <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sub_q       <= sub_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      acc_q       <= acc_d;
      result_q    <= result_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zero_q      <= zero_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sub_d       = sub_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    acc_d       = acc_q;
    result_d    = result_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zero_d      = zero_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          sub_d      = sub;
          idx_d      = '0;
          carry_d    = sub;
          acc_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        a_d     = WIDTH'(a_q >> CHUNK);
        b_d     = WIDTH'(b_q >> CHUNK);
        acc_d   = acc_next_c;
        carry_d = chunk_cout_c;
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NCHUNK - 1)) begin
          result_d    = acc_next_c;
          cout_d      = chunk_cout_c;
          ovf_d       = ovf_next_c;
          zero_d      = (acc_next_c == '0);
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // Consuming edge only returns to IDLE; acceptance waits for the next edge.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule : chunked_add_sub

// File: tb/tb_chunked_add_sub.sv
// Directed testbench for chunked_add_sub with WIDTH=16, CHUNK=4.
module tb_chunked_add_sub;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned CHUNK = 4;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             cout;
  logic             ovf;
  logic             zero;

  int n_checks;
  int n_fail;

  chunked_add_sub #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one operation, optionally disturb inputs during RUN, hold the
  // result for 'hold' cycles, then consume it and check the return to IDLE.
  task automatic run_op(input string tag,
                        input logic [15:0] av, input logic [15:0] bv, input logic sv,
                        input logic [15:0] er, input logic ec, input logic eo, input logic ez,
                        input int hold, input bit disturb);
    int lat;
    @(negedge clk);
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, ".in_ready_run"}, 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (disturb && lat == 1) begin
        a = 16'hFFFF; b = 16'hFFFF; sub = ~sv; in_valid = 1'b1;
      end
      if (disturb && lat == 3) in_valid = 1'b0;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd4);
    chk({tag, ".result"}, 32'(result), 32'(er));
    chk({tag, ".cout"}, 32'(cout), 32'(ec));
    chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
    chk({tag, ".zero"}, 32'(zero), 32'(ez));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({tag, ".hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, ".hold_ready"}, 32'(in_ready), 32'd0);
      chk({tag, ".hold_result"}, 32'({cout, ovf, zero, result}), 32'({ec, eo, ez, er}));
    end
    // Consume while also offering a new operand: it must not be taken this edge.
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b0;
    chk({tag, ".consumed_valid"}, 32'(out_valid), 32'd0);
    chk({tag, ".consumed_ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".result_held"}, 32'(result), 32'(er));
    @(posedge clk); #1;
    chk({tag, ".no_extra_op"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sub = 1'b0;
    #12;
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.result", 32'({cout, ovf, zero, result}), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    run_op("add_basic", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 0, 1'b0);
    run_op("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    run_op("sub_zero",  16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    run_op("sub_borrow",16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    run_op("sub_ovf",   16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0, 1'b0);
    run_op("backpress", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 3, 1'b0);
    run_op("disturb",   16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    run_op("sub_mixed", 16'h3000, 16'h4000, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    // Leave nonzero flags registered so the reset clearing is observable.
    run_op("pre_reset", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 0, 1'b0);

    // Abort mid-RUN after two chunks have been processed.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("midreset.out_valid", 32'(out_valid), 32'd0);
    chk("midreset.in_ready", 32'(in_ready), 32'd1);
    chk("midreset.flags_result", 32'({cout, ovf, zero, result}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("after_reset", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_chunked_add_sub
